lbm_sweep_controller: RTL and testbench

//  Sequences the D2Q9 distribution RAM (DEPTH nodes x 9 packed 32-bit f_i) through in-place collision sweeps.

---
 rtl/lbm_pkg.sv | 21 ++
 rtl/lbm_sweep_controller_if.sv | 41 ++++
 rtl/lbm_node_counter.sv | 59 +++++
 rtl/lbm_sweep_controller.sv | 162 ++++++++++++++++
 tb/tb_lbm_sweep_controller.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lbm_pkg.sv
// rtl/lbm_pkg.sv - D2Q9 lattice constants, distribution word type and sweep FSM states
package lbm_pkg;

    localparam int Q          = 9;
    localparam int F_WIDTH    = 32;
    localparam int LBM_DEPTH  = 256;
    localparam int DIST_WIDTH = Q * F_WIDTH;

    typedef logic signed [DIST_WIDTH-1:0] dist_word_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_COLLECT = 3'd4,
        ST_WRITE   = 3'd5,
        ST_DONE    = 3'd6
    } sweep_state_e;

endpackage

// File: rtl/lbm_sweep_controller_if.sv
// rtl/lbm_sweep_controller_if.sv - distribution RAM port and collision-unit handshake bundle
interface lbm_sweep_controller_if
    import lbm_pkg::*;
#(
    parameter int ADDRESS_WIDTH = $clog2(LBM_DEPTH),
    parameter int DATA_WIDTH    = DIST_WIDTH
);

    logic [ADDRESS_WIDTH-1:0] ram_address;
    logic                     ram_we;
    logic [DATA_WIDTH-1:0]    ram_data_in;
    logic [DATA_WIDTH-1:0]    ram_data_out;

    logic                     col_in_valid;
    logic                     col_in_ready;
    logic [DATA_WIDTH-1:0]    col_in_data;
    logic [ADDRESS_WIDTH-1:0] col_in_addr;

    logic                     col_out_valid;
    logic                     col_out_ready;
    logic [DATA_WIDTH-1:0]    col_out_data;

    modport master (
        output ram_address, ram_we, ram_data_in,
        input  ram_data_out,
        output col_in_valid, col_in_data, col_in_addr,
        input  col_in_ready,
        input  col_out_valid, col_out_data,
        output col_out_ready
    );

    modport slave (
        input  ram_address, ram_we, ram_data_in,
        output ram_data_out,
        input  col_in_valid, col_in_data, col_in_addr,
        output col_in_ready,
        output col_out_valid, col_out_data,
        input  col_out_ready
    );

endinterface

// File: rtl/lbm_node_counter.sv
// rtl/lbm_node_counter.sv - node address and sweep counters with wrap at DEPTH-1
module lbm_node_counter
    import lbm_pkg::*;
#(
    parameter int DEPTH         = LBM_DEPTH,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int STEP_WIDTH    = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     advance_i,
    input  logic [STEP_WIDTH-1:0]    num_steps_i,
    output logic [ADDRESS_WIDTH-1:0] addr_o,
    output logic [STEP_WIDTH-1:0]    step_count_o,
    output logic                     last_node_o,
    output logic                     last_step_o
);

    // Explicit compare so a non power-of-two lattice wraps correctly
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [STEP_WIDTH-1:0]    step_q, step_d;
    logic [STEP_WIDTH-1:0]    step_inc;

    assign step_inc     = step_q + STEP_WIDTH'(1);
    assign last_node_o  = (addr_q == LAST_ADDR);
    assign last_step_o  = (step_inc == num_steps_i);
    assign addr_o       = addr_q;
    assign step_count_o = step_q;

    always_comb begin
        addr_d = addr_q;
        step_d = step_q;
        if (clear_i) begin
            addr_d = '0;
            step_d = '0;
        end else if (advance_i) begin
            if (last_node_o) begin
                addr_d = '0;
                step_d = step_inc;
            end else begin
                addr_d = addr_q + ADDRESS_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q <= '0;
            step_q <= '0;
        end else begin
            addr_q <= addr_d;
            step_q <= step_d;
        end
    end

endmodule

// File: rtl/lbm_sweep_controller.sv
// rtl/lbm_sweep_controller.sv - in-place D2Q9 collision sweep sequencer, one node in flight
// Optional LBM_SWEEP_CYCLE_COUNT_EN adds a saturating busy-cycle counter port.
module lbm_sweep_controller
    import lbm_pkg::*;
#(
    parameter int DEPTH         = LBM_DEPTH,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = DIST_WIDTH,
    parameter int STEP_WIDTH    = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [STEP_WIDTH-1:0] num_steps_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [STEP_WIDTH-1:0] step_count_o,
`ifdef LBM_SWEEP_CYCLE_COUNT_EN
    output logic [31:0]           cycle_count_o,
`endif
    lbm_sweep_controller_if.master bus
);

    sweep_state_e             state_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     ram_we_q;
    logic                     col_in_valid_q;
    logic                     col_out_ready_q;
    logic [STEP_WIDTH-1:0]    num_steps_q;
    logic [DATA_WIDTH-1:0]    col_in_data_q;
    logic [DATA_WIDTH-1:0]    ram_data_in_q;

    logic                     start_accept;
    logic                     advance;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     last_node;
    logic                     last_step;

    assign start_accept = (state_q == ST_IDLE) && start_i;
    assign advance      = (state_q == ST_WRITE);

    lbm_node_counter #(
        .DEPTH         (DEPTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .STEP_WIDTH    (STEP_WIDTH)
    ) u_node_counter (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clear_i      (start_accept),
        .advance_i    (advance),
        .num_steps_i  (num_steps_q),
        .addr_o       (addr),
        .step_count_o (step_count_o),
        .last_node_o  (last_node),
        .last_step_o  (last_step)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            ram_we_q        <= 1'b0;
            col_in_valid_q  <= 1'b0;
            col_out_ready_q <= 1'b0;
            num_steps_q     <= '0;
            col_in_data_q   <= '0;
            ram_data_in_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        num_steps_q <= num_steps_i;
                        if (num_steps_i == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_READ;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    col_in_data_q  <= bus.ram_data_out;
                    col_in_valid_q <= 1'b1;
                    state_q        <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (bus.col_in_ready) begin
                        col_in_valid_q  <= 1'b0;
                        col_out_ready_q <= 1'b1;
                        state_q         <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (bus.col_out_valid) begin
                        ram_data_in_q   <= bus.col_out_data;
                        col_out_ready_q <= 1'b0;
                        ram_we_q        <= 1'b1;
                        state_q         <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Node counter advances on this same edge
                    ram_we_q <= 1'b0;
                    if (last_node && last_step) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_READ;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LBM_SWEEP_CYCLE_COUNT_EN
    logic [31:0] cycle_count_q, cycle_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (start_accept) begin
            cycle_count_d = '0;
        end else if (busy_q && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count_o = cycle_count_q;
`endif

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign bus.ram_address   = addr;
    assign bus.ram_we        = ram_we_q;
    assign bus.ram_data_in   = ram_data_in_q;
    assign bus.col_in_valid  = col_in_valid_q;
    assign bus.col_in_data   = col_in_data_q;
    assign bus.col_in_addr   = addr;
    assign bus.col_out_ready = col_out_ready_q;

endmodule

// File: tb/tb_lbm_sweep_controller.sv
// tb/tb_lbm_sweep_controller.sv - randomized self-checking bench with RAM and collision-unit models
module tb_lbm_sweep_controller;
    import lbm_pkg::*;

    localparam int DEPTH = LBM_DEPTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = DIST_WIDTH;
    localparam int SW    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] num_steps = '0;
    logic          busy, done;
    logic [SW-1:0] step_count;
`ifdef LBM_SWEEP_CYCLE_COUNT_EN
    logic [31:0]   cycle_count;
`endif

    lbm_sweep_controller_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    lbm_sweep_controller #(
        .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .STEP_WIDTH(SW)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .num_steps_i  (num_steps),
        .busy_o       (busy),
        .done_o       (done),
        .step_count_o (step_count),
`ifdef LBM_SWEEP_CYCLE_COUNT_EN
        .cycle_count_o(cycle_count),
`endif
        .bus          (bus.master)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Environment state: RAM contents, collision unit, run statistics
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] init_mem [DEPTH];
    int            wr_cnt [DEPTH];
    int            wr_total, order_err, exp_next, busy_cycles, done_cnt;
    int            we_run_err, stable_err, data_err;
    bit            rand_mode = 0;
    bit            arm_active = 0;
    logic [AW-1:0] arm_addr = '0;
    int            arm_in_stall = 0, arm_out_delay = 0;

    function automatic logic [DW-1:0] add_lanes(input logic [DW-1:0] w, input int n);
        logic [DW-1:0] r;
        for (int q = 0; q < Q; q++) r[q*F_WIDTH +: F_WIDTH] = w[q*F_WIDTH +: F_WIDTH] + F_WIDTH'(n);
        return r;
    endfunction

    // Words below split expect +inc_lo over the snapshot, the rest +inc_hi
    function automatic int mem_bad(input int inc_lo, input int inc_hi, input int split);
        int bad = 0;
        for (int a = 0; a < DEPTH; a++)
            if (mem[a] !== add_lanes(init_mem[a], (a < split) ? inc_lo : inc_hi)) bad++;
        return bad;
    endfunction

    function automatic int not_once();
        int bad = 0;
        for (int a = 0; a < DEPTH; a++) if (wr_cnt[a] != 1) bad++;
        return bad;
    endfunction

    initial begin : env
        bit            have_result = 0;
        logic [DW-1:0] result = '0;
        int            out_wait = 0, stall = 0, next_delay = 0;
        bit            prev_valid = 0, prev_we = 0;
        logic [DW-1:0] prev_data = '0;
        bus.ram_data_out  = '0;
        bus.col_in_ready  = 1'b0;
        bus.col_out_valid = 1'b0;
        bus.col_out_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                have_result = 0; stall = 0; prev_valid = 0; prev_we = 0;
                bus.col_out_valid = 1'b0;
                bus.col_in_ready  = 1'b0;
            end else begin
                if (bus.ram_we === 1'b1) begin
                    mem[bus.ram_address] = bus.ram_data_in;
                    wr_total++;
                    wr_cnt[bus.ram_address]++;
                    if (int'(bus.ram_address) != exp_next) order_err++;
                    exp_next = (int'(bus.ram_address) + 1) % DEPTH;
                    if (prev_we) we_run_err++;
                end
                prev_we = (bus.ram_we === 1'b1);
                bus.ram_data_out = mem[bus.ram_address];
                if (busy === 1'b1) busy_cycles++;
                if (done === 1'b1) done_cnt++;

                if (have_result) begin
                    if (out_wait > 0) begin
                        out_wait--;
                        bus.col_out_valid = 1'b0;
                    end else begin
                        bus.col_out_valid = 1'b1;
                        bus.col_out_data  = result;
                        if (bus.col_out_ready === 1'b1) have_result = 0;
                    end
                end else begin
                    bus.col_out_valid = 1'b0;
                end

                if (bus.col_in_valid === 1'b1 && prev_valid && bus.col_in_data !== prev_data) stable_err++;
                if (bus.col_in_valid === 1'b1 && !prev_valid) begin
                    if (arm_active && bus.col_in_addr == arm_addr) begin
                        stall = arm_in_stall; next_delay = arm_out_delay; arm_active = 0;
                    end else if (rand_mode) begin
                        stall = $urandom_range(0, 3); next_delay = $urandom_range(0, 3);
                    end else begin
                        stall = 0; next_delay = 0;
                    end
                    if (bus.col_in_data !== mem[bus.col_in_addr]) data_err++;
                end
                prev_valid = (bus.col_in_valid === 1'b1);
                prev_data  = bus.col_in_data;
                if (bus.col_in_valid === 1'b1 && stall > 0) begin
                    bus.col_in_ready = 1'b0;
                    stall--;
                end else begin
                    bus.col_in_ready = 1'b1;
                    if (bus.col_in_valid === 1'b1 && !have_result) begin
                        have_result = 1;
                        result      = add_lanes(bus.col_in_data, 1);
                        out_wait    = next_delay;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(); reset = 1'b1;
        tick(); tick(); reset = 1'b0;
    endtask

    task automatic clear_stats();
        for (int a = 0; a < DEPTH; a++) wr_cnt[a] = 0;
        wr_total = 0; order_err = 0; exp_next = 0; busy_cycles = 0; done_cnt = 0;
        we_run_err = 0; stable_err = 0; data_err = 0;
        for (int a = 0; a < DEPTH; a++) init_mem[a] = mem[a];
    endtask

    task automatic preload(input bit random_words);
        logic [DW-1:0] w;
        for (int a = 0; a < DEPTH; a++) begin
            for (int q = 0; q < Q; q++) w[q*F_WIDTH +: F_WIDTH] = random_words ? $urandom : a;
            mem[a] = w;
        end
    endtask

    task automatic start_run(input int n);
        tick(); num_steps = SW'(n); start = 1'b1;
        tick(); start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        bit seen = 0;
        cycles = 1;
        while (!seen && cycles <= budget) begin
            if (done === 1'b1) seen = 1;
            else begin tick(); cycles++; end
        end
        check({tag, "_done_seen"}, seen, 1);
        tick(); tick();
    endtask

    task automatic check_run(input string tag, input int steps, input int busy_exp);
        check({tag, "_mem"}, mem_bad(steps, steps, DEPTH), 0);
        check({tag, "_step_count"}, step_count, steps);
        check({tag, "_writes"}, wr_total, steps * DEPTH);
        check({tag, "_order"}, order_err, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_cycles"}, busy_cycles, busy_exp);
        check({tag, "_we_single"}, we_run_err, 0);
        check({tag, "_offer_data"}, data_err, 0);
    endtask

    initial begin : main
        int  cyc;
        bit  found;
        int  n;
        preload(0);
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", bus.ram_we, 0);
        check("rst_in_valid", bus.col_in_valid, 0);
        check("rst_out_ready", bus.col_out_ready, 0);
        check("rst_step_count", step_count, 0);
        check("rst_address", bus.ram_address, 0);

        // 1: one sweep, word = addr per lane, ideal collision unit
        clear_stats();
        start_run(1);
        wait_done("t1", 3000, cyc);
        check_run("t1", 1, 5 * DEPTH);
        check("t1_word_ff", mem[255][F_WIDTH-1:0], 32'h100);
        check("t1_done_low", done, 0);

        // 2: zero steps
        clear_stats();
        start_run(0);
        wait_done("t2", 10, cyc);
        check("t2_latency_le2", (cyc <= 2), 1);
        check("t2_writes", wr_total, 0);
        check("t2_mem", mem_bad(0, 0, DEPTH), 0);
        check("t2_busy_cycles", busy_cycles, 0);
        check("t2_done_pulses", done_cnt, 1);
        check("t2_step_count", step_count, 0);

        // 3: backpressure and slow result at node 0x12
        preload(1);
        clear_stats();
        arm_addr = 8'h12; arm_in_stall = 3; arm_out_delay = 4; arm_active = 1;
        start_run(1);
        wait_done("t3", 3000, cyc);
        check_run("t3", 1, 5 * DEPTH + 3 + 4);
        check("t3_stable", stable_err, 0);
        check("t3_wr_0x12", wr_cnt[8'h12], 1);
        check("t3_each_once", not_once(), 0);

        // 4: three sweeps, wrap between sweeps
        clear_stats();
        start_run(3);
        wait_done("t4", 8000, cyc);
        check_run("t4", 3, 3 * 5 * DEPTH);

        // 5: reset while collecting node 0x40, then clean rerun
        preload(1);
        clear_stats();
        arm_addr = 8'h40; arm_in_stall = 0; arm_out_delay = 6; arm_active = 1;
        start_run(1);
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (bus.col_out_ready === 1'b1 && bus.col_in_addr == 8'h40) found = 1;
            else tick();
        end
        check("t5_reached_collect", found, 1);
        reset = 1'b1;
        tick();
        check("t5_busy_after_rst", busy, 0);
        check("t5_we_after_rst", bus.ram_we, 0);
        check("t5_out_ready_after_rst", bus.col_out_ready, 0);
        check("t5_in_valid_after_rst", bus.col_in_valid, 0);
        tick();
        reset = 1'b0;
        check("t5_partial_mem", mem_bad(1, 0, 8'h40), 0);
        check("t5_partial_writes", wr_total, 8'h40);
        clear_stats();
        start_run(1);
        wait_done("t5b", 3000, cyc);
        check_run("t5b", 1, 5 * DEPTH);

        // 6: start while busy is ignored
        clear_stats();
        start_run(1);
        for (int i = 0; i < 100; i++) tick();
        num_steps = 16'd7; start = 1'b1;
        tick(); start = 1'b0;
        wait_done("t6", 3000, cyc);
        check_run("t6", 1, 5 * DEPTH);
`ifdef LBM_SWEEP_CYCLE_COUNT_EN
        check("t6_cycle_count", cycle_count, 5 * DEPTH);
`endif

        // 7: randomized words and handshake timing
        rand_mode = 1;
        preload(1);
        clear_stats();
        n = $urandom_range(1, 2);
        start_run(n);
        wait_done("t7", 25000, cyc);
        check("t7_mem", mem_bad(n, n, DEPTH), 0);
        check("t7_step_count", step_count, n);
        check("t7_writes", wr_total, n * DEPTH);
        check("t7_order", order_err, 0);
        check("t7_stable", stable_err, 0);
        check("t7_offer_data", data_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
